avmm_master_arbiter: RTL and testbench

//  Shares one downstream Avalon-MM slave path between the FPGA-side and HPS-side JTAG masters.

---
 rtl/avmm_arb_pkg.sv | 13 +
 rtl/avmm_id_fifo.sv | 52 +++++
 rtl/avmm_master_arbiter.sv | 148 ++++++++++++++
 tb/tb_avmm_master_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared types and master IDs for the two-master Avalon-MM arbiter.
package avmm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_FPGA,
    BUSY_HPS
  } arb_state_t;

  localparam logic ID_FPGA = 1'b0;
  localparam logic ID_HPS  = 1'b1;

endpackage

// File: rtl/avmm_id_fifo.sv
// In-order FIFO of 1-bit master IDs for outstanding reads; register storage.
module avmm_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage needs no reset; entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/avmm_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM path between FPGA and HPS JTAG masters.
// Define AVMM_ARB_FIXED_PRIO_EN to make HPS win every tie instead.
module avmm_master_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic [AW-1:0]   fpga_s_address,
  input  logic            fpga_s_read,
  input  logic            fpga_s_write,
  input  logic [DW-1:0]   fpga_s_writedata,
  input  logic [DW/8-1:0] fpga_s_byteenable,
  output logic            fpga_s_waitrequest,
  output logic [DW-1:0]   fpga_s_readdata,
  output logic            fpga_s_readdatavalid,
  input  logic [AW-1:0]   hps_s_address,
  input  logic            hps_s_read,
  input  logic            hps_s_write,
  input  logic [DW-1:0]   hps_s_writedata,
  input  logic [DW/8-1:0] hps_s_byteenable,
  output logic            hps_s_waitrequest,
  output logic [DW-1:0]   hps_s_readdata,
  output logic            hps_s_readdatavalid,
  output logic [AW-1:0]   m_address,
  output logic            m_read,
  output logic            m_write,
  output logic [DW-1:0]   m_writedata,
  output logic [DW/8-1:0] m_byteenable,
  input  logic            m_waitrequest,
  input  logic [DW-1:0]   m_readdata,
  input  logic            m_readdatavalid,
  output logic            rsp_err
);

  arb_state_t state, state_d;
  logic grant, grant_id, accept, owner_id, tie_id;
  logic fpga_elig, hps_elig;
  logic fifo_full, fifo_empty, head_id;

  // A read that cannot be tracked waits; a write is always eligible.
  assign fpga_elig = fpga_s_read ? ~fifo_full : fpga_s_write;
  assign hps_elig  = hps_s_read  ? ~fifo_full : hps_s_write;
  assign owner_id  = (state == BUSY_HPS) ? ID_HPS : ID_FPGA;

`ifdef AVMM_ARB_FIXED_PRIO_EN
  assign tie_id = ID_HPS;
`else
  logic last_grant;
  assign tie_id = ~last_grant;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  last_grant <= ID_HPS;
    else if (accept)     last_grant <= owner_id;
  end
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d            = state;
    grant              = 1'b0;
    grant_id           = ID_FPGA;
    accept             = 1'b0;
    fpga_s_waitrequest = 1'b1;
    hps_s_waitrequest  = 1'b1;
    unique case (state)
      IDLE: begin
        if (fpga_elig || hps_elig) begin
          grant    = 1'b1;
          grant_id = (fpga_elig && hps_elig) ? tie_id : (hps_elig ? ID_HPS : ID_FPGA);
          state_d  = (grant_id == ID_HPS) ? BUSY_HPS : BUSY_FPGA;
        end
      end
      BUSY_FPGA: begin
        fpga_s_waitrequest = m_waitrequest;
        if (!m_waitrequest) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      BUSY_HPS: begin
        hps_s_waitrequest = m_waitrequest;
        if (!m_waitrequest) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic            sel_read, sel_write;
  logic [AW-1:0]   sel_address;
  logic [DW-1:0]   sel_writedata;
  logic [DW/8-1:0] sel_byteenable;

  assign sel_read       = (grant_id == ID_HPS) ? hps_s_read        : fpga_s_read;
  assign sel_write      = (grant_id == ID_HPS) ? hps_s_write       : fpga_s_write;
  assign sel_address    = (grant_id == ID_HPS) ? hps_s_address     : fpga_s_address;
  assign sel_writedata  = (grant_id == ID_HPS) ? hps_s_writedata   : fpga_s_writedata;
  assign sel_byteenable = (grant_id == ID_HPS) ? hps_s_byteenable  : fpga_s_byteenable;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state <= state_d;
      if (grant) begin
        // Read wins when a master raises both; the write is dropped.
        m_read       <= sel_read;
        m_write      <= sel_write & ~sel_read;
        m_address    <= sel_address;
        m_writedata  <= sel_writedata;
        m_byteenable <= sel_byteenable;
      end else if (accept) begin
        m_read  <= 1'b0;
        m_write <= 1'b0;
      end
      if (m_readdatavalid && fifo_empty) rsp_err <= 1'b1;
    end
  end

  avmm_id_fifo #(.DEPTH(MAX_PENDING)) u_id_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (accept & m_read),
    .push_id (owner_id),
    .pop     (m_readdatavalid),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fpga_s_readdata      = m_readdata;
  assign hps_s_readdata       = m_readdata;
  assign fpga_s_readdatavalid = m_readdatavalid & ~fifo_empty & (head_id == ID_FPGA);
  assign hps_s_readdatavalid  = m_readdatavalid & ~fifo_empty & (head_id == ID_HPS);

endmodule

// File: tb/tb_avmm_master_arbiter.sv
// Self-checking bench for avmm_master_arbiter: directed scenarios plus randomized traffic.
module tb_avmm_master_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXP = 4;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } cmd_t;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b1;
  logic [AW-1:0] fpga_s_address, hps_s_address, m_address;
  logic          fpga_s_read, fpga_s_write, hps_s_read, hps_s_write, m_read, m_write;
  logic [DW-1:0] fpga_s_writedata, hps_s_writedata, m_writedata;
  logic [BW-1:0] fpga_s_byteenable, hps_s_byteenable, m_byteenable;
  logic          fpga_s_waitrequest, hps_s_waitrequest, m_waitrequest;
  logic [DW-1:0] fpga_s_readdata, hps_s_readdata, m_readdata;
  logic          fpga_s_readdatavalid, hps_s_readdatavalid, m_readdatavalid;
  logic          rsp_err;

  avmm_master_arbiter #(.AW(AW), .DW(DW), .MAX_PENDING(MAXP)) dut (
    .clk_clk              (clk_clk),
    .reset_reset_n        (reset_reset_n),
    .fpga_s_address       (fpga_s_address),
    .fpga_s_read          (fpga_s_read),
    .fpga_s_write         (fpga_s_write),
    .fpga_s_writedata     (fpga_s_writedata),
    .fpga_s_byteenable    (fpga_s_byteenable),
    .fpga_s_waitrequest   (fpga_s_waitrequest),
    .fpga_s_readdata      (fpga_s_readdata),
    .fpga_s_readdatavalid (fpga_s_readdatavalid),
    .hps_s_address        (hps_s_address),
    .hps_s_read           (hps_s_read),
    .hps_s_write          (hps_s_write),
    .hps_s_writedata      (hps_s_writedata),
    .hps_s_byteenable     (hps_s_byteenable),
    .hps_s_waitrequest    (hps_s_waitrequest),
    .hps_s_readdata       (hps_s_readdata),
    .hps_s_readdatavalid  (hps_s_readdatavalid),
    .m_address            (m_address),
    .m_read               (m_read),
    .m_write              (m_write),
    .m_writedata          (m_writedata),
    .m_byteenable         (m_byteenable),
    .m_waitrequest        (m_waitrequest),
    .m_readdata           (m_readdata),
    .m_readdatavalid      (m_readdatavalid),
    .rsp_err              (rsp_err)
  );

  always #5 clk_clk = ~clk_clk;

  // Reference model: IDs of accepted reads in issue order, who won last, sticky error.
  int   total = 0;
  int   bad   = 0;
  bit   exp_q[$];
  bit   last_hps  = 1'b1;
  bit   exp_err   = 1'b0;
  bit   rand_stall = 1'b0;
  cmd_t fcmd, hcmd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tie_hps();
`ifdef AVMM_ARB_FIXED_PRIO_EN
    return 1'b1;
`else
    return !last_hps;
`endif
  endfunction

  // kind: 0 idle, 1 read, 2 write, 3 read+write
  function automatic cmd_t rand_cmd(input int kind);
    cmd_t c;
    c.rd   = (kind == 1) || (kind == 3);
    c.wr   = (kind == 2) || (kind == 3);
    c.addr = $urandom;
    c.data = $urandom;
    c.be   = BW'($urandom_range(1, (1 << BW) - 1));
    return c;
  endfunction

  task automatic next();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic drive_f(input bit on);
    fpga_s_read       = on & fcmd.rd;
    fpga_s_write      = on & fcmd.wr;
    fpga_s_address    = fcmd.addr;
    fpga_s_writedata  = fcmd.data;
    fpga_s_byteenable = fcmd.be;
  endtask

  task automatic drive_h(input bit on);
    hps_s_read       = on & hcmd.rd;
    hps_s_write      = on & hcmd.wr;
    hps_s_address    = hcmd.addr;
    hps_s_writedata  = hcmd.data;
    hps_s_byteenable = hcmd.be;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_m_cmd"}, {m_read, m_write}, 2'b00);
    check({tag, "_m_addr"}, m_address, 0);
    check({tag, "_m_wdata"}, {m_writedata, m_byteenable}, 0);
    check({tag, "_wait"}, {fpga_s_waitrequest, hps_s_waitrequest}, 2'b11);
    check({tag, "_rdv"}, {fpga_s_readdatavalid, hps_s_readdatavalid}, 2'b00);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  task automatic reset_dut(input string tag);
    fcmd = rand_cmd(0);
    hcmd = rand_cmd(0);
    drive_f(0);
    drive_h(0);
    m_readdatavalid = 1'b0;
    m_waitrequest   = 1'b0;
    reset_reset_n   = 1'b0;
    #1;
    check_reset_vals(tag);
    next();
    reset_reset_n = 1'b1;
    next();
    exp_q.delete();
    last_hps = 1'b1;
    exp_err  = 1'b0;
  endtask

  // Waits for an owner's waitrequest to drop; returns at the negedge of that cycle.
  task automatic wait_accept(output bit who_hps, output bit ok);
    ok = 1'b0;
    who_hps = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_clk);
      if (!fpga_s_waitrequest || !hps_s_waitrequest) begin
        who_hps = !hps_s_waitrequest;
        ok = 1'b1;
        check("single_owner", {fpga_s_waitrequest, hps_s_waitrequest},
              who_hps ? 2'b10 : 2'b01);
        return;
      end
      next();
      if (rand_stall) m_waitrequest = ($urandom_range(0, 3) == 0);
    end
    check("accept_timeout", ok, 1'b1);
  endtask

  task automatic verify_accept(input bit who);
    cmd_t c = who ? hcmd : fcmd;
    check("m_read", m_read, c.rd);
    check("m_write", m_write, c.wr & ~c.rd);
    check("m_address", m_address, c.addr);
    if (!c.rd) check("m_wdata_be", {m_writedata, m_byteenable}, {c.data, c.be});
    if (c.rd) exp_q.push_back(who);
    last_hps = who;
    next();
    if (who) drive_h(0);
    else     drive_f(0);
  endtask

  task automatic serve(input cmd_t f, input cmd_t h);
    bit pf, ph, who, ok, pred;
    fcmd = f;
    hcmd = h;
    pf = f.rd | f.wr;
    ph = h.rd | h.wr;
    drive_f(pf);
    drive_h(ph);
    while (pf || ph) begin
      pred = (pf && ph) ? tie_hps() : ph;
      wait_accept(who, ok);
      if (!ok) break;
      check("grant_owner", who, pred);
      verify_accept(who);
      if (who) ph = 1'b0;
      else     pf = 1'b0;
    end
    drive_f(0);
    drive_h(0);
  endtask

  task automatic send_rdv();
    logic [DW-1:0] d = $urandom;
    bit has = (exp_q.size() > 0);
    bit hid = has ? exp_q[0] : 1'b0;
    m_readdatavalid = 1'b1;
    m_readdata      = d;
    @(negedge clk_clk);
    check("rdv_fpga", fpga_s_readdatavalid, has && !hid);
    check("rdv_hps", hps_s_readdatavalid, has && hid);
    check("rdata", {fpga_s_readdata, hps_s_readdata}, {d, d});
    if (has) exp_q.delete(0);
    else     exp_err = 1'b1;
    next();
    m_readdatavalid = 1'b0;
    check("rsp_err", rsp_err, exp_err);
  endtask

  initial begin
    bit who, ok;
    m_readdata = '0;
    #2;
    reset_dut("por");

    // Single FPGA write: command appears one cycle after the request.
    fcmd = '{rd: 1'b0, wr: 1'b1, addr: 32'h10, data: 32'hA5A5_A5A5, be: 4'hF};
    drive_f(1);
    @(negedge clk_clk);
    check("t1_idle_wait", {fpga_s_waitrequest, m_write}, 2'b10);
    next();
    @(negedge clk_clk);
    check("t1_m_write", {m_read, m_write}, 2'b01);
    check("t1_m_addr", m_address, 32'h10);
    check("t1_m_wdata", m_writedata, 32'hA5A5_A5A5);
    check("t1_wait", {fpga_s_waitrequest, hps_s_waitrequest}, 2'b01);
    next();
    drive_f(0);
    @(negedge clk_clk);
    check("t1_m_write_clr", m_write, 1'b0);
    next();

    // Simultaneous reads from both masters, twice: alternating grants, routed responses.
    reset_dut("t2_rst");
    repeat (2) serve(rand_cmd(1), rand_cmd(1));
    repeat (4) send_rdv();

    // FIFO full blocks a fifth read but not a write.
    repeat (MAXP) serve(rand_cmd(1), rand_cmd(0));
    fcmd = rand_cmd(1);
    drive_f(1);
    repeat (6) begin
      @(negedge clk_clk);
      check("t3_full_wait", {fpga_s_waitrequest, m_read}, 2'b10);
      next();
    end
    hcmd = rand_cmd(2);
    drive_h(1);
    wait_accept(who, ok);
    check("t3_hps_write", who, 1'b1);
    verify_accept(who);
    send_rdv();
    wait_accept(who, ok);
    check("t3_fifth_read", who, 1'b0);
    verify_accept(who);
    repeat (MAXP) send_rdv();

    // Downstream stall during an HPS read: command held, FPGA stalled.
    hcmd = rand_cmd(1);
    fcmd = rand_cmd(2);
    m_waitrequest = 1'b1;
    drive_h(1);
    next();
    drive_f(1);
    repeat (5) begin
      @(negedge clk_clk);
      check("t4_hold_cmd", {m_read, m_address}, {1'b1, hcmd.addr});
      check("t4_hold_wait", {fpga_s_waitrequest, hps_s_waitrequest}, 2'b11);
      next();
    end
    m_waitrequest = 1'b0;
    wait_accept(who, ok);
    check("t4_hps_first", who, 1'b1);
    verify_accept(who);
    wait_accept(who, ok);
    check("t4_fpga_second", who, 1'b0);
    verify_accept(who);
    send_rdv();

    // Response with nothing outstanding: no upstream strobe, sticky error.
    send_rdv();
    repeat (3) begin
      next();
      check("t5_err_sticky", rsp_err, 1'b1);
    end

    // Reset with reads outstanding and a stalled command in flight.
    serve(rand_cmd(1), rand_cmd(0));
    serve(rand_cmd(0), rand_cmd(1));
    hcmd = rand_cmd(1);
    m_waitrequest = 1'b1;
    drive_h(1);
    next();
    next();
    reset_dut("t6_rst");
    send_rdv();

    // Randomized traffic with random downstream stalls and interleaved responses.
    reset_dut("t7_rst");
    rand_stall = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int kf = $urandom_range(0, 3);
      int kh = $urandom_range(0, 3);
      if (kf == 0 && kh == 0) kf = 1;
      while (exp_q.size() > MAXP - 2) send_rdv();
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) send_rdv();
      serve(rand_cmd(kf), rand_cmd(kh));
    end
    rand_stall = 1'b0;
    m_waitrequest = 1'b0;
    while (exp_q.size() > 0) send_rdv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
